// File: rtl/fifo_wr_arb_pkg.sv
// Shared definitions for the FIFO write-port scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// State encoding of the write scheduler and the grant identifiers used
// between the arbiter and the FSM.
package fifo_wr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RF_WR   = 2'b01,
        ALU_LSB = 2'b10,
        ALU_MSB = 2'b11
    } state_e;

    localparam logic GNT_RF  = 1'b0;
    localparam logic GNT_ALU = 1'b1;

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter_2.sv
// Two-requester grant logic (register file vs ALU) for the FIFO write port.
// Latency: combinational grant; last-grant memory updates on the accepting edge.
// Backpressure: grants are only consumed when arb_en_i is high (scheduler idle).
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   rf_req_i          register file request
//   alu_req_i         ALU request
//   arb_en_i          scheduler is idle and will act on the grant this edge
//   gnt_vld_o         some requester is granted
//   gnt_id_o          GNT_RF or GNT_ALU
//
// Build option FIFO_WR_ARB_FIXED_PRIO_EN: when defined, ALU always wins a
// tie and no last-grant state exists; otherwise ties alternate round-robin.
module rr_arbiter_2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rf_req_i,
    input  logic alu_req_i,
    input  logic arb_en_i,
    output logic gnt_vld_o,
    output logic gnt_id_o
);
    import fifo_wr_arb_pkg::*;

    assign gnt_vld_o = rf_req_i | alu_req_i;

`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
    // Fixed priority has no state, so clock/reset/enable are not needed.
    logic unused_ctrl;
    assign unused_ctrl = clk_i ^ rst_i ^ arb_en_i;

    assign gnt_id_o = alu_req_i ? GNT_ALU : GNT_RF;
`else
    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt_id_o = GNT_RF;
        if (rf_req_i && alu_req_i) begin
            // Tie: favour whoever was not served last.
            gnt_id_o = (last_grant_q == GNT_ALU) ? GNT_RF : GNT_ALU;
        end else if (alu_req_i) begin
            gnt_id_o = GNT_ALU;
        end
    end

    assign last_grant_d = (arb_en_i && gnt_vld_o) ? gnt_id_o : last_grant_q;

    // Reset to ALU so the register file wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= GNT_ALU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port between the ALU (2-byte result, LSB first) and the register file (1 byte).
// Latency: REQ sampled at edge n -> ACK and first W_INC in cycle n+1; ALU MSB in n+2; one IDLE between transactions.
// Backpressure: FIFO FULL stalls the current state indefinitely with W_INC low; no byte lost or duplicated.
//
// Ports:
//   clk_i, rst_i              write-domain clock, synchronous active-high reset
//   alu_req_i / alu_data_i    ALU result request, data held until alu_ack_o
//   alu_ack_o                 one-cycle capture pulse for the ALU
//   rf_req_i / rf_data_i      register file request, data held until rf_ack_o
//   rf_ack_o                  one-cycle capture pulse for the register file
//   fifo_full_i               FIFO full flag (already in this clock domain)
//   wr_data_o / w_inc_o       FIFO write data and write strobe
//   busy_o                    high whenever a transaction is in progress
//
// Build option FIFO_WR_ARB_FIXED_PRIO_EN selects fixed ALU priority in the
// arbiter instead of round-robin.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    alu_req_i,
    input  logic [2*DATA_WIDTH-1:0] alu_data_i,
    output logic                    alu_ack_o,
    input  logic                    rf_req_i,
    input  logic [DATA_WIDTH-1:0]   rf_data_i,
    output logic                    rf_ack_o,
    input  logic                    fifo_full_i,
    output logic [DATA_WIDTH-1:0]   wr_data_o,
    output logic                    w_inc_o,
    output logic                    busy_o
);
    import fifo_wr_arb_pkg::*;

    state_e                  state_q, state_d;
    logic [2*DATA_WIDTH-1:0] hold_q, hold_d;
    logic                    alu_ack_q, alu_ack_d;
    logic                    rf_ack_q, rf_ack_d;
    logic                    busy_q, busy_d;
    logic                    gnt_vld;
    logic                    gnt_id;

    rr_arbiter_2 u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rf_req_i  (rf_req_i),
        .alu_req_i (alu_req_i),
        .arb_en_i  (state_q == IDLE),
        .gnt_vld_o (gnt_vld),
        .gnt_id_o  (gnt_id)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        alu_ack_d = 1'b0;
        rf_ack_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    if (gnt_id == GNT_RF) begin
                        state_d  = RF_WR;
                        // RF byte sits in the low half so the LSB mux serves both.
                        hold_d   = {{DATA_WIDTH{1'b0}}, rf_data_i};
                        rf_ack_d = 1'b1;
                    end else begin
                        state_d   = ALU_LSB;
                        hold_d    = alu_data_i;
                        alu_ack_d = 1'b1;
                    end
                end
            end
            RF_WR:   if (!fifo_full_i) state_d = IDLE;
            ALU_LSB: if (!fifo_full_i) state_d = ALU_MSB;
            ALU_MSB: if (!fifo_full_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            alu_ack_q <= 1'b0;
            rf_ack_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            alu_ack_q <= alu_ack_d;
            rf_ack_q  <= rf_ack_d;
            busy_q    <= busy_d;
        end
    end

    // Strobe is registered state gated by the live FULL flag, so a write
    // never coincides with FULL; data comes straight from the hold register.
    assign w_inc_o   = (state_q != IDLE) && !fifo_full_i;
    assign wr_data_o = (state_q == ALU_MSB) ? hold_q[2*DATA_WIDTH-1:DATA_WIDTH]
                                            : hold_q[DATA_WIDTH-1:0];
    assign alu_ack_o = alu_ack_q;
    assign rf_ack_o  = rf_ack_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: cycle checks plus a captured write-byte stream.
// Latency: n/a.
// Backpressure: FIFO full driven directly by the stimulus.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_req;
    logic [15:0] alu_data;
    logic        alu_ack;
    logic        rf_req;
    logic [7:0]  rf_data;
    logic        rf_ack;
    logic        fifo_full;
    logic [7:0]  wr_data;
    logic        w_inc;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  got_q[$];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DATA_WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .alu_req_i   (alu_req),
        .alu_data_i  (alu_data),
        .alu_ack_o   (alu_ack),
        .rf_req_i    (rf_req),
        .rf_data_i   (rf_data),
        .rf_ack_o    (rf_ack),
        .fifo_full_i (fifo_full),
        .wr_data_o   (wr_data),
        .w_inc_o     (w_inc),
        .busy_o      (busy)
    );

    // Record every byte that the FIFO would accept.
    always @(negedge clk) begin
        if (w_inc) got_q.push_back(wr_data);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stream(input string tag, input logic [7:0] exp[$]);
        chk({tag, "_len"}, got_q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            chk(tag, (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hFFFF_FFFF, {24'h0, exp[i]});
        end
        got_q.delete();
    endtask

    logic [7:0] exp_q[$];

    initial begin
        rst = 1'b1; alu_req = 1'b1; rf_req = 1'b1;
        rf_data = 8'h11; alu_data = 16'hBBAA; fifo_full = 1'b0;

        // 1: reset held with both requests pending.
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_w_inc", w_inc, 0);
            chk("rst_acks", {alu_ack, rf_ack}, 0);
            chk("rst_busy", busy, 0);
            chk("rst_wr_data", wr_data, 0);
        end
        got_q.delete();
        rst = 1'b0;

        // 4: both requests continuously high.
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) begin
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
                chk("first_grant_ack", {alu_ack, rf_ack}, 2'b10);
                chk("first_grant_data", wr_data, 8'hAA);
`else
                chk("first_grant_ack", {alu_ack, rf_ack}, 2'b01);
                chk("first_grant_data", wr_data, 8'h11);
`endif
                chk("first_grant_busy", busy, 1);
            end
        end
        alu_req = 1'b0; rf_req = 1'b0;
        repeat (3) tick();
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
        exp_q = '{8'hAA, 8'hBB, 8'hAA, 8'hBB, 8'hAA, 8'hBB, 8'hAA, 8'hBB};
`else
        exp_q = '{8'h11, 8'hAA, 8'hBB, 8'h11, 8'hAA, 8'hBB};
`endif
        chk_stream("tie_stream", exp_q);

        // 2: single register file byte.
        rf_req = 1'b1; rf_data = 8'hA5;
        tick();
        chk("rf_ack", {alu_ack, rf_ack}, 2'b01);
        chk("rf_w_inc", w_inc, 1);
        chk("rf_wr_data", wr_data, 8'hA5);
        chk("rf_busy", busy, 1);
        rf_req = 1'b0;
        tick();
        chk("rf_done_ack", {alu_ack, rf_ack}, 0);
        chk("rf_done_w_inc", w_inc, 0);
        chk("rf_done_busy", busy, 0);
        tick();
        exp_q = '{8'hA5};
        chk_stream("rf_stream", exp_q);

        // 3: ALU result, LSB then MSB on consecutive cycles.
        alu_req = 1'b1; alu_data = 16'h1234;
        tick();
        chk("alu_ack", {alu_ack, rf_ack}, 2'b10);
        chk("alu_lsb_w_inc", w_inc, 1);
        chk("alu_lsb_data", wr_data, 8'h34);
        alu_req = 1'b0;
        tick();
        chk("alu_ack_pulse", alu_ack, 0);
        chk("alu_msb_w_inc", w_inc, 1);
        chk("alu_msb_data", wr_data, 8'h12);
        chk("alu_msb_busy", busy, 1);
        tick();
        chk("alu_done_w_inc", w_inc, 0);
        chk("alu_done_busy", busy, 0);
        tick();
        exp_q = '{8'h34, 8'h12};
        chk_stream("alu_stream", exp_q);

        // 5: FULL for 3 cycles while the MSB is pending.
        alu_req = 1'b1; alu_data = 16'h1234;
        tick();
        chk("stall_lsb_data", wr_data, 8'h34);
        alu_req = 1'b0;
        tick();
        fifo_full = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            chk("stall_w_inc", w_inc, 0);
            chk("stall_data", wr_data, 8'h12);
            chk("stall_busy", busy, 1);
        end
        fifo_full = 1'b0;
        #1;
        chk("stall_release_w_inc", w_inc, 1);
        chk("stall_release_data", wr_data, 8'h12);
        tick();
        chk("stall_done_w_inc", w_inc, 0);
        chk("stall_done_busy", busy, 0);
        tick();
        exp_q = '{8'h34, 8'h12};
        chk_stream("stall_stream", exp_q);

        // 6: reset in the LSB cycle discards the MSB.
        alu_req = 1'b1; alu_data = 16'h1234;
        tick();
        chk("rst_mid_lsb", wr_data, 8'h34);
        rst = 1'b1; alu_req = 1'b0;
        tick();
        chk("rst_mid_w_inc", w_inc, 0);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b0;
        repeat (2) begin
            tick();
            chk("rst_mid_after_w_inc", w_inc, 0);
        end
        exp_q = '{8'h34};
        chk_stream("rst_mid_stream", exp_q);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
